// File: rtl/sl_transmitter_if.sv
// Host-side bus of the SL transmitter: config access, word hand-off, status
// and the two serial lines, grouped so the bench and the design share one bundle.
interface sl_transmitter_if;
    logic [15:0] wr_config_w;
    logic        wr_enable;
    logic [15:0] r_config_w;
    logic [31:0] tx_data;
    logic        tx_start;
    logic        tx_ready;
    logic        serial_line_zeroes;
    logic        serial_line_ones;
    logic [15:0] status_w;
    logic        data_status_changed;

    modport master (
        output wr_config_w, wr_enable, tx_data, tx_start,
        input  r_config_w, tx_ready, serial_line_zeroes, serial_line_ones,
               status_w, data_status_changed
    );

    modport slave (
        input  wr_config_w, wr_enable, tx_data, tx_start,
        output r_config_w, tx_ready, serial_line_zeroes, serial_line_ones,
               status_w, data_status_changed
    );
endinterface

// File: rtl/sl_transmitter.sv
// SL transmitter: sends an 8..32 bit word as a two-line SL frame with per-line parity
// and an end marker. Optional parity-error injection is enabled by SL_TX_ERR_INJECT_EN.
module sl_transmitter #(
    parameter int BASE_T      = 8,
    parameter int DEFAULT_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    sl_transmitter_if.slave   bus
);
    localparam int PW = $clog2(4 * BASE_T) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_BIT, S_GAP, S_PARITY, S_POST, S_MARK, S_TAIL
    } state_t;

    // Parity of the ones in the low n bits; with n even the zero count has the same parity.
    function automatic logic word_parity(input logic [31:0] d, input logic [5:0] n);
        logic [31:0] m;
        m = (n >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        return ^(d & m);
    endfunction

    state_t          r_state;
    logic [PW-1:0]   r_pre;
    logic [1:0]      r_sub;
    logic [4:0]      r_idx;
    logic [31:0]     r_shift;
    logic            r_par;
    logic [5:0]      r_cfg_len, r_f_len;
    logic [1:0]      r_cfg_rate, r_f_rate;
    logic            r_cfg_inj, r_f_inj;
    logic            r_cfg_err;
    logic            r_zero, r_one, r_ready, r_busy, r_sent, r_dsc;

    logic [5:0]      w_wr_len;
    logic            w_wr_ok;
    logic            w_inj_wr;
    logic            w_unused_bits;
    logic [PW-1:0]   w_half, w_hlim;
    logic            w_slot_end;
    logic            w_last_bit;

    assign w_wr_len      = bus.wr_config_w[6:1];
    assign w_wr_ok       = !w_wr_len[0] && (w_wr_len >= 6'd8) && (w_wr_len <= 6'd32);
`ifdef SL_TX_ERR_INJECT_EN
    assign w_inj_wr      = bus.wr_config_w[9];
`else
    assign w_inj_wr      = 1'b0;
`endif
    assign w_unused_bits = ^{bus.wr_config_w[15:9], bus.wr_config_w[0]};

    assign w_half     = PW'(BASE_T / 2) << r_f_rate;
    assign w_hlim     = w_half - PW'(1);
    assign w_slot_end = (r_pre == w_hlim);
    assign w_last_bit = ({1'b0, r_idx} == (r_f_len - 6'd1));

    assign bus.r_config_w          = {6'd0, r_cfg_inj, r_cfg_rate, r_cfg_len, 1'b0};
    assign bus.tx_ready            = r_ready;
    assign bus.serial_line_zeroes  = r_zero;
    assign bus.serial_line_ones    = r_one;
    assign bus.status_w            = {13'd0, r_sent, r_cfg_err, r_busy};
    assign bus.data_status_changed = r_dsc;

    // Config register: valid writes update it at once, frames pick it up at start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_len  <= 6'(DEFAULT_LEN);
            r_cfg_rate <= 2'd0;
            r_cfg_inj  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else if (bus.wr_enable) begin
            if (w_wr_ok) begin
                r_cfg_len  <= w_wr_len;
                r_cfg_rate <= bus.wr_config_w[8:7];
                r_cfg_inj  <= w_inj_wr;
                r_cfg_err  <= 1'b0;
            end else begin
                r_cfg_err  <= 1'b1;
            end
        end
    end

    // Frame FSM: one H slot per prescaler period, line levels set on slot entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pre    <= '0;
            r_sub    <= 2'd0;
            r_idx    <= 5'd0;
            r_shift  <= 32'd0;
            r_par    <= 1'b0;
            r_f_len  <= 6'(DEFAULT_LEN);
            r_f_rate <= 2'd0;
            r_f_inj  <= 1'b0;
            r_zero   <= 1'b1;
            r_one    <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_sent   <= 1'b0;
            r_dsc    <= 1'b0;
        end else begin
            r_dsc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.tx_start) begin
                        r_state  <= S_BIT;
                        r_pre    <= '0;
                        r_sub    <= 2'd0;
                        r_idx    <= 5'd0;
                        r_shift  <= bus.tx_data;
                        r_par    <= word_parity(bus.tx_data, r_cfg_len);
                        r_f_len  <= r_cfg_len;
                        r_f_rate <= r_cfg_rate;
                        r_f_inj  <= r_cfg_inj;
                        r_zero   <= 1'b1;
                        r_one    <= 1'b1;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_sent   <= 1'b0;
                    end
                end
                default: begin
                    if (!w_slot_end) begin
                        r_pre <= r_pre + PW'(1);
                        // Flag the final TAIL cycle one edge early so the pulse is registered.
                        if ((r_state == S_TAIL) && (r_pre == (w_hlim - PW'(1)))) begin
                            r_dsc  <= 1'b1;
                            r_sent <= 1'b1;
                        end
                    end else begin
                        r_pre <= '0;
                        r_sub <= r_sub + 2'd1;
                        case (r_state)
                            S_BIT: begin
                                case (r_sub)
                                    2'd0: begin
                                        r_zero <= r_shift[0];
                                        r_one  <= ~r_shift[0];
                                    end
                                    2'd1: begin
                                        r_zero <= r_zero;
                                    end
                                    2'd2: begin
                                        r_zero <= 1'b1;
                                        r_one  <= 1'b1;
                                    end
                                    default: begin
                                        if (w_last_bit) begin
                                            r_state <= S_GAP;
                                        end else begin
                                            r_idx   <= r_idx + 5'd1;
                                            r_shift <= {1'b0, r_shift[31:1]};
                                        end
                                    end
                                endcase
                            end
                            S_GAP: begin
                                r_state <= S_PARITY;
                                r_sub   <= 2'd0;
                                r_zero  <= ~(r_par ^ r_f_inj);
                                r_one   <= r_par ^ r_f_inj;
                            end
                            S_PARITY: begin
                                if (r_sub == 2'd1) begin
                                    r_state <= S_POST;
                                    r_sub   <= 2'd0;
                                    r_zero  <= 1'b1;
                                    r_one   <= 1'b1;
                                end
                            end
                            S_POST: begin
                                if (r_sub == 2'd1) begin
                                    r_state <= S_MARK;
                                    r_sub   <= 2'd0;
                                    r_zero  <= 1'b0;
                                    r_one   <= 1'b0;
                                end
                            end
                            S_MARK: begin
                                if (r_sub == 2'd1) begin
                                    r_state <= S_TAIL;
                                    r_sub   <= 2'd0;
                                    r_zero  <= 1'b1;
                                    r_one   <= 1'b1;
                                end
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_sub   <= 2'd0;
                                r_zero  <= 1'b1;
                                r_one   <= 1'b1;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sl_transmitter.sv
// Directed bench for sl_transmitter: table of frames checked cycle by cycle against a
// slot model, plus sequences for config errors, shadow config, back-to-back and reset.
module tb_sl_transmitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    sl_transmitter_if sl_if ();

    sl_transmitter #(.BASE_T(8), .DEFAULT_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sl_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  len;
        logic [1:0]  rate;
        logic        pz;
        logic        po;
        int          total;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Expected {zeroes, ones} in frame cycle c (1-based), H = h cycles.
    function automatic logic [1:0] exp_lines(input int c, input logic [31:0] d, input int len,
                                             input int h, input logic pz, input logic po);
        int slot, s, r;
        slot = (c - 1) / h;
        if (slot < 4 * len) begin
            s = slot % 4;
            if (s == 1 || s == 2) return d[slot / 4] ? 2'b10 : 2'b01;
            return 2'b11;
        end
        r = slot - 4 * len;
        case (r)
            1, 2:    return {pz, po};
            5, 6:    return 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    task automatic wr_cfg(input logic [5:0] len, input logic [1:0] rate, input logic inj);
        sl_if.wr_config_w = {6'd0, inj, rate, len, 1'b0};
        sl_if.wr_enable   = 1'b1;
        @(negedge clk);
        sl_if.wr_enable   = 1'b0;
    endtask

    // Called just after a negedge with tx_ready expected high; returns at the negedge
    // of the first cycle after the frame.
    task automatic run_frame(input string nm, input logic [31:0] data, input logic [5:0] len,
                             input logic [1:0] rate, input logic pz, input logic po,
                             input int total, input logic hold, input logic [5:0] mid_len);
        int h, bad_cyc, dsc_n, dsc_cyc, rdy_n;
        logic [1:0] e, bad_act, bad_exp;
        h = 4 << rate;
        bad_cyc = 0; dsc_n = 0; dsc_cyc = 0; rdy_n = 0;
        bad_act = 2'b00; bad_exp = 2'b00;
        check({nm, "_ready_in"}, {31'd0, sl_if.tx_ready}, 32'd1);
        sl_if.tx_data  = data;
        sl_if.tx_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) sl_if.tx_start = 1'b0;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            e = exp_lines(c, data, int'(len), h, pz, po);
            if ({sl_if.serial_line_zeroes, sl_if.serial_line_ones} !== e && bad_cyc == 0) begin
                bad_cyc = c;
                bad_act = {sl_if.serial_line_zeroes, sl_if.serial_line_ones};
                bad_exp = e;
            end
            if (sl_if.data_status_changed) begin
                dsc_n++;
                if (dsc_cyc == 0) dsc_cyc = c;
            end
            if (sl_if.tx_ready || !sl_if.status_w[0]) rdy_n++;
            if (c == 40) sl_if.tx_data = ~data;
            if (!hold && c == 30) sl_if.tx_start = 1'b1;
            if (!hold && c == 31) sl_if.tx_start = 1'b0;
            if (mid_len != 6'd0 && c == 20) begin
                sl_if.wr_config_w = {9'd0, mid_len, 1'b0};
                sl_if.wr_enable   = 1'b1;
            end
            if (mid_len != 6'd0 && c == 21) begin
                sl_if.wr_enable = 1'b0;
                check({nm, "_shadow_rb"}, {16'd0, sl_if.r_config_w}, {25'd0, mid_len, 1'b0});
            end
        end
        n_checks++;
        if (bad_cyc != 0) begin
            n_errors++;
            $display("FAIL %s_lines: cycle %0d got %b want %b", nm, bad_cyc, bad_act, bad_exp);
        end
        check({nm, "_dsc_count"}, dsc_n, 1);
        check({nm, "_dsc_cycle"}, dsc_cyc, total);
        check({nm, "_busy_during"}, rdy_n, 0);
        @(negedge clk);
        check({nm, "_ready_after"}, {31'd0, sl_if.tx_ready}, 32'd1);
        check({nm, "_sent_after"}, {30'd0, sl_if.status_w[2], sl_if.status_w[0]}, 32'd2);
    endtask

    initial begin
        // data, len, rate, parity zeroes, parity ones, frame cycles (4N+8)*H
        vecs[0] = '{32'h0000_00A5, 6'd8,  2'd0, 1'b1, 1'b0, 160};
        vecs[1] = '{32'hFFFF_FFFF, 6'd32, 2'd2, 1'b1, 1'b0, 2176};
        vecs[2] = '{32'h0000_1234, 6'd16, 2'd1, 1'b0, 1'b1, 576};
        vecs[3] = '{32'hDEAD_BEEF, 6'd10, 2'd0, 1'b1, 1'b0, 192};
        vecs[4] = '{32'h0000_0007, 6'd8,  2'd3, 1'b0, 1'b1, 1280};

        sl_if.wr_config_w = 16'd0;
        sl_if.wr_enable   = 1'b0;
        sl_if.tx_data     = 32'd0;
        sl_if.tx_start    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_lines", {30'd0, sl_if.serial_line_zeroes, sl_if.serial_line_ones}, 32'd3);
        check("rst_ready", {31'd0, sl_if.tx_ready}, 32'd1);
        check("rst_status", {16'd0, sl_if.status_w}, 32'd0);
        check("rst_dsc", {31'd0, sl_if.data_status_changed}, 32'd0);
        check("rst_config", {16'd0, sl_if.r_config_w}, 32'h0010);

        for (int i = 0; i < 5; i++) begin
            wr_cfg(vecs[i].len, vecs[i].rate, 1'b0);
            check($sformatf("vec%0d_cfg_rb", i), {16'd0, sl_if.r_config_w},
                  {23'd0, vecs[i].rate, vecs[i].len, 1'b0});
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].len, vecs[i].rate,
                      vecs[i].pz, vecs[i].po, vecs[i].total, 1'b0, 6'd0);
        end

        // Invalid lengths leave the config alone and raise the sticky error.
        wr_cfg(6'd8, 2'd0, 1'b0);
        wr_cfg(6'd9, 2'd0, 1'b0);
        check("bad9_err", {31'd0, sl_if.status_w[1]}, 32'd1);
        check("bad9_rb", {16'd0, sl_if.r_config_w}, 32'h0010);
        wr_cfg(6'd34, 2'd0, 1'b0);
        check("bad34_err", {31'd0, sl_if.status_w[1]}, 32'd1);
        check("bad34_rb", {16'd0, sl_if.r_config_w}, 32'h0010);
        run_frame("after_bad", 32'h0000_00A5, 6'd8, 2'd0, 1'b1, 1'b0, 160, 1'b0, 6'd0);

        // Write N=16 during an N=8 frame: current frame stays at 8, next uses 16.
        run_frame("shadow8", 32'h0000_003C, 6'd8, 2'd0, 1'b1, 1'b0, 160, 1'b0, 6'd16);
        check("shadow_err_clr", {31'd0, sl_if.status_w[1]}, 32'd0);
        run_frame("shadow16", 32'h0000_003C, 6'd16, 2'd0, 1'b1, 1'b0, 288, 1'b0, 6'd0);

        // Back-to-back with tx_start held high.
        wr_cfg(6'd8, 2'd0, 1'b0);
        run_frame("b2b_a", 32'h0000_00A5, 6'd8, 2'd0, 1'b1, 1'b0, 160, 1'b1, 6'd0);
        run_frame("b2b_b", 32'h0000_003C, 6'd8, 2'd0, 1'b1, 1'b0, 160, 1'b1, 6'd0);
        sl_if.tx_start = 1'b0;
        @(negedge clk);
        check("b2b_idle", {31'd0, sl_if.tx_ready}, 32'd1);

`ifdef SL_TX_ERR_INJECT_EN
        wr_cfg(6'd8, 2'd0, 1'b1);
        check("inj_rb", {16'd0, sl_if.r_config_w}, 32'h0210);
        run_frame("inj", 32'h0000_00A5, 6'd8, 2'd0, 1'b0, 1'b1, 160, 1'b0, 6'd0);
`else
        wr_cfg(6'd8, 2'd0, 1'b1);
        check("inj_rb", {16'd0, sl_if.r_config_w}, 32'h0010);
        run_frame("inj", 32'h0000_00A5, 6'd8, 2'd0, 1'b1, 1'b0, 160, 1'b0, 6'd0);
`endif
        wr_cfg(6'd8, 2'd0, 1'b0);

        // Reset in the middle of bit 3 of an N=16 frame with the error flag raised.
        wr_cfg(6'd16, 2'd0, 1'b0);
        wr_cfg(6'd9, 2'd0, 1'b0);
        check("pre_rst_err", {31'd0, sl_if.status_w[1]}, 32'd1);
        sl_if.tx_data  = 32'h0000_0008;
        sl_if.tx_start = 1'b1;
        @(posedge clk);
        #1;
        sl_if.tx_start = 1'b0;
        repeat (54) @(negedge clk);
        check("bit3_active", {30'd0, sl_if.serial_line_zeroes, sl_if.serial_line_ones}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_lines", {30'd0, sl_if.serial_line_zeroes, sl_if.serial_line_ones}, 32'd3);
        check("midrst_ready", {31'd0, sl_if.tx_ready}, 32'd1);
        check("midrst_status", {16'd0, sl_if.status_w}, 32'd0);
        check("midrst_config", {16'd0, sl_if.r_config_w}, 32'h0010);
        run_frame("post_rst", 32'h0000_00A5, 6'd8, 2'd0, 1'b1, 1'b0, 160, 1'b0, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sl_transmitter.md
Name: sl_transmitter

Overview:
- Serial-line (SL) transmitter: converts a parallel word of 8..32 bits into an SL frame on two wires, the "zeroes" line and the "ones" line, with per-line parity and an end marker.
- Wire-compatible with SL_receiver; it is the sending end of the same link.
- Sits on the same register-style host interface as the receiver: config write and readback, data word, status word, and a one-cycle change pulse.

Parameters:
- BASE_T, 8, clk cycles per SL unit T at rate select 0. Must be even and >= 4.
- DEFAULT_LEN, 8, word length after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- wr_config_w  in  16  config write data
- wr_enable  in  1  config write strobe, one cycle
- r_config_w  out  16  active config readback
- tx_data  in  32  word to send, LSB first; bits at and above the configured length are ignored
- tx_start  in  1  start request
- tx_ready  out  1  idle; tx_start is accepted only when high
- serial_line_zeroes  out  1  SL zeroes line, idle high
- serial_line_ones  out  1  SL ones line, idle high
- status_w  out  16  [0] busy, [1] config error (sticky), [2] frame sent (sticky); others 0
- data_status_changed  out  1  one-cycle pulse at end of each frame

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset:
  - both lines 1, tx_ready=1, status_w=0, data_status_changed=0.
  - Config: length=DEFAULT_LEN, rate=0, r_config_w=DEFAULT_LEN<<1.
  - Reset mid-frame aborts the frame; the lines are 1 on the cycle after reset.
- Config format: [6:1] length N, [8:7] rate R, [9] inject (optional feature), [0] and [15:10] reserved, read 0.
- Config validity:
  - Valid when N is even and 8<=N<=32.
  - Invalid write: config unchanged, status[1] set until the next valid write.
  - A write while busy is held in a shadow register and takes effect at the next frame start; readback shows the shadow.
- Timing units:
  - T = BASE_T<<R clk cycles; H = T/2.
  - Each H is counted by a prescaler, restarted at frame start.
- Handshake:
  - tx_start && tx_ready on edge k: latch tx_data and config, tx_ready=0 from k+1.
  - First H slot begins at cycle k+1; outputs are registered.
  - tx_start while busy is ignored (not queued).
- FSM: IDLE -> BIT -> GAP -> PARITY -> POST -> MARK -> TAIL -> IDLE.
- Frame, in H slots (both lines 1 unless stated):
  - Per data bit i=0..N-1, 4H:
    - 1H both high.
    - 2H: the active line low (zeroes line if bit=0, ones line if bit=1); the other line high.
    - 1H both high.
  - GAP: 1H.
  - PARITY: 2H, zeroes line = 1 XOR (count of zeros mod 2), ones line = (count of ones mod 2).
  - POST: 2H.
  - MARK: 2H, both lines low.
  - TAIL: 1H.
  - Total (4N+8)H cycles.
- End of frame:
  - In the last cycle of TAIL, data_status_changed pulses and status[2] is set.
  - tx_ready=1 on the next cycle; a new start is accepted that same cycle (back-to-back).
  - status[2] is cleared on the next accepted start.
- Parity accumulates over the latched word only; changing tx_data mid-frame has no effect.
- Lines are never both low except during MARK.

Optional Feature:
- Macro SL_TX_ERR_INJECT_EN.
- Defined:
  - config[9]=1 inverts both parity levels for every frame sent while it is set.
  - Used for receiver parity-error testing.
  - config[9] reads back.
- Undefined: config[9] is ignored, reads 0, and parity is always correct.

Test Plan:
- Reset with BASE_T=8, then config N=8, R=0, tx_data=0xA5, start ->
  - frame is 160 cycles;
  - ones line low cycles 5..12 (bit0=1), zeroes line low cycles 21..28 (bit1=0);
  - PARITY: zeroes=1, ones=0;
  - both low during MARK;
  - data_status_changed at cycle 160; tx_ready=1 at 161.
- N=32, R=2 (T=32, H=16), tx_data=0xFFFFFFFF ->
  - zeroes line never low before MARK;
  - ones-line parity 0, zeroes-line parity 1;
  - frame 2176 cycles.
- Config write N=9, then N=34 ->
  - status[1]=1, r_config_w unchanged;
  - the next frame still uses the previous N.
- Config write N=16 during an N=8 frame ->
  - current frame completes at N=8, next frame uses 16;
  - r_config_w shows 16 immediately.
- Back-to-back: tx_start held high ->
  - second frame starts the cycle tx_ready rises, with no idle gap;
  - tx_start pulsed mid-frame is ignored.
- Reset asserted at bit 3 ->
  - lines 1 and tx_ready=1 next cycle;
  - config back to N=8; status_w=0.
- With SL_TX_ERR_INJECT_EN: inject=1, tx_data=0xA5 -> PARITY zeroes=0, ones=1.
